// File: rtl/const_high.sv
// Logic-1 tie-off source: constant y/y_n/y_vec plus a registered settle flag
// and a sticky self-check on the sampled tie for consumers wanting a registered tie.
module const_high #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             y,
   output logic             y_n,
   output logic [WIDTH-1:0] y_vec,
   output logic             settled,
   output logic             fault
);

   localparam logic [7:0] SETTLE_COUNT = 8'(SETTLE_CYCLES);

   // Constant ties are pure continuous assignments: valid from time 0, independent of clk/rst.
   assign y   = 1'b1;
   assign y_n = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_vec
         assign y_vec[gi] = 1'b1;
      end
   endgenerate

   logic [7:0] count_reg;
   logic [7:0] count_next;
   logic       settled_reg;
   logic       fault_reg;

   // Saturating count of edges since reset release.
   always_comb begin
      count_next = count_reg;
      if (count_reg < SETTLE_COUNT) begin
         count_next = count_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg   <= 8'd0;
         settled_reg <= 1'b0;
         fault_reg   <= 1'b0;
      end else begin
         count_reg   <= count_next;
         settled_reg <= (count_next == SETTLE_COUNT);
         fault_reg   <= fault_reg | (y !== 1'b1);
      end
   end

   assign settled = settled_reg;
   assign fault   = fault_reg;

endmodule

// File: tb/tb_const_high.sv
// Self-checking bench for const_high: constant ties, settle timing, async reset,
// long-run saturation and parameter overrides, against an edge-count model.
module tb_const_high;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        y, y_n, settled, fault;
   logic [7:0]  y_vec;
   logic        y1, y1_n, settled1, fault1;
   logic [0:0]  y1_vec;
   logic        y64, y64_n, settled64, fault64;
   logic [63:0] y64_vec;

   wire         clk_f;
   wire         rst_f;
   logic        yf, yf_n, settledf, faultf;
   logic [7:0]  yf_vec;

   assign clk_f = 1'bz;
   assign rst_f = 1'bz;

   always #5 clk = ~clk;

   const_high dut (
      .clk(clk), .rst(rst), .y(y), .y_n(y_n), .y_vec(y_vec),
      .settled(settled), .fault(fault)
   );

   const_high #(.WIDTH(1), .SETTLE_CYCLES(4)) dut_w1 (
      .clk(clk), .rst(rst), .y(y1), .y_n(y1_n), .y_vec(y1_vec),
      .settled(settled1), .fault(fault1)
   );

   const_high #(.WIDTH(64), .SETTLE_CYCLES(1)) dut_w64 (
      .clk(clk), .rst(rst), .y(y64), .y_n(y64_n), .y_vec(y64_vec),
      .settled(settled64), .fault(fault64)
   );

   const_high dut_float (
      .clk(clk_f), .rst(rst_f), .y(yf), .y_n(yf_n), .y_vec(yf_vec),
      .settled(settledf), .fault(faultf)
   );

   int errors = 0;
   int checks = 0;
   int edges  = 0;       // model: rising edges seen with rst low since last reset
   int y_changes = 0;

   always @(y or yf or y_n or y_vec) begin
      if ($time > 0) y_changes++;
   end

   // Advance one clock and compare every instance against the edge-count model.
   task automatic step_and_check(input string tag);
      logic       exp_s4;
      logic       exp_s1;
      @(posedge clk);
      #1;
      if (!rst && edges < 1000000) edges++;
      exp_s4 = (edges >= 4);
      exp_s1 = (edges >= 1);
      checks++;
      if (settled !== exp_s4) begin
         errors++;
         $display("FAIL %s settled: got %b expected %b (edges=%0d)", tag, settled, exp_s4, edges);
      end
      checks++;
      if (settled1 !== exp_s4) begin
         errors++;
         $display("FAIL %s settled_w1: got %b expected %b (edges=%0d)", tag, settled1, exp_s4, edges);
      end
      checks++;
      if (settled64 !== exp_s1) begin
         errors++;
         $display("FAIL %s settled_w64: got %b expected %b (edges=%0d)", tag, settled64, exp_s1, edges);
      end
      checks++;
      if ({fault, fault1, fault64} !== 3'b000) begin
         errors++;
         $display("FAIL %s fault: got %b%b%b expected 000", tag, fault, fault1, fault64);
      end
      checks++;
      if (y !== 1'b1 || y_n !== 1'b0 || y_vec !== 8'hFF) begin
         errors++;
         $display("FAIL %s ties: got y=%b y_n=%b y_vec=%h expected 1 0 ff", tag, y, y_n, y_vec);
      end
   endtask

   task automatic assert_reset_async(input string tag);
      @(negedge clk);
      #($urandom_range(1, 3));
      rst = 1'b1;
      edges = 0;
      #1;
      checks++;
      if ({settled, settled1, settled64, fault, fault1, fault64} !== 6'b0) begin
         errors++;
         $display("FAIL %s async_clear: got s=%b%b%b f=%b%b%b expected all 0",
                  tag, settled, settled1, settled64, fault, fault1, fault64);
      end
      checks++;
      if (y !== 1'b1 || y64 !== 1'b1) begin
         errors++;
         $display("FAIL %s y_in_reset: got %b/%b expected 1/1", tag, y, y64);
      end
   endtask

   task automatic test_const_floating();
      int sample_t[4] = '{1, 10, 30, 60};
      foreach (sample_t[i]) begin
         #(sample_t[i] - $time);
         checks++;
         if (yf !== 1'b1 || yf_n !== 1'b0 || yf_vec !== 8'hFF) begin
            errors++;
            $display("FAIL float_ties@%0t: got y=%b y_n=%b y_vec=%h expected 1 0 ff",
                     $time, yf, yf_n, yf_vec);
         end
         checks++;
         if (y1_vec !== 1'b1 || y64_vec !== {64{1'b1}} || y1_n !== 1'b0 || y64_n !== 1'b0) begin
            errors++;
            $display("FAIL param_ties@%0t: got w1=%b w64=%h expected 1 and all ones",
                     $time, y1_vec, y64_vec);
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({settled, settled1, settled64, fault, fault1, fault64} !== 6'b0 || y !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got s=%b%b%b f=%b%b%b y=%b expected 0s and y=1",
                  settled, settled1, settled64, fault, fault1, fault64, y);
      end
      @(negedge clk);
      rst = 1'b0;
      edges = 0;
      for (int i = 0; i < 6; i++) step_and_check("settle");
   endtask

   task automatic test_async_reset();
      assert_reset_async("mid_settled");
      step_and_check("held_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step_and_check("restart");
   endtask

   task automatic test_random_resets();
      for (int n = 0; n < 25; n++) begin
         int run = $urandom_range(0, 7);
         int hold = $urandom_range(0, 2);
         for (int i = 0; i < run; i++) step_and_check("rand_run");
         assert_reset_async("rand_rst");
         for (int i = 0; i < hold; i++) step_and_check("rand_hold");
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   task automatic test_long_run();
      for (int i = 0; i < 1000; i++) step_and_check("long");
      checks++;
      if (y_changes !== 0) begin
         errors++;
         $display("FAIL tie_stability: got %0d transitions expected 0", y_changes);
      end
   endtask

   initial begin
      test_const_floating();
      test_reset();
      test_async_reset();
      test_random_resets();
      test_long_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/const_high.md
Name: const_high

Overview:
- Logic-1 tie-off source for the gate library.
- Primary output y is a hard constant 1 at all times, with no dependence on clock, reset or any input.
- Auxiliary outputs provide a constant-1 vector, a constant-0 complement and a clocked "settled" status with a self-check for downstream consumers that want a registered tie.
- Sits at the leaf level; instantiated wherever a gate input must be tied high.

Parameters:
- WIDTH, 8, width of the all-ones vector output y_vec (legal 1..64).
- SETTLE_CYCLES, 4, clock cycles after reset release before settled asserts (legal 1..255).

Ports:
- clk  input  1  system clock, rising-edge; may be left unconnected.
- rst  input  1  asynchronous active-high reset; may be left unconnected.
- y  output  1  constant logic 1.
- y_n  output  1  constant logic 0 (complement of y).
- y_vec  output  WIDTH  constant all ones.
- settled  output  1  registered flag: SETTLE_CYCLES clocks have elapsed since reset release.
- fault  output  1  registered flag: the sampled copy of y was ever seen not equal to 1 since reset.

Behaviour:
- Constant outputs (y, y_n, y_vec):
  - y driven by a continuous assignment to 1'b1. It is purely combinational with no register, gate delay or X window.
  - y equals 1 from time 0 of simulation, including before any clock edge and during reset.
  - y equals 1 with clk and rst floating (z) or X.
  - y_n = 1'b0 and y_vec = {WIDTH{1'b1}}, same rules as y.
  - None of these three outputs may change value at any simulation time.
- Settle counter:
  - Counter width is 8 bits.
  - On rst=1 (asynchronous), counter clears to 0 and settled = 0.
  - After release, the counter increments on each rising clk edge while count < SETTLE_CYCLES, then saturates.
  - settled = 1 when count == SETTLE_CYCLES. It is registered, so settled rises on the SETTLE_CYCLES-th rising edge after rst deasserts.
  - Reset mid-count or after settled returns count to 0 and settled to 0 immediately (asynchronous).
  - Reset deassertion is treated as synchronous to clk; no extra synchronizer.
- Self-check:
  - On each rising edge with rst=0, if y != 1'b1 (including X/Z under === compare in simulation), fault sets to 1.
  - fault is sticky until rst.
  - rst=1 clears fault to 0 asynchronously.
  - In correct hardware fault is always 0.
- Reset values:
  - settled=0, fault=0, internal count=0.
  - y=1, y_n=0, y_vec=all ones; these are unaffected by reset.
- With clk unconnected, settled and fault may be X; y, y_n and y_vec must still be valid constants.
- No handshake and no data path; no other state.

Test Plan:
- clk/rst unconnected; sample y at t=0, 10, 30, 60 ns -> y=1 at every sample, y_n=0, y_vec=8'hFF; no transition ever recorded on y.
- Pulse rst=1 for 20 ns with 10 ns clock, then release -> y stays 1 throughout reset; settled=0 during reset and for the first 3 edges after release, then settled=1 on the 4th rising edge.
- Assert rst asynchronously between edges after settled=1 -> settled and fault go to 0 immediately without a clock edge; y remains 1; count restarts after release.
- Run 1000 clock cycles after reset -> fault remains 0 throughout; settled remains 1 after saturation (counter does not wrap).
- Override parameters WIDTH=1 and WIDTH=64, SETTLE_CYCLES=1 -> y_vec all ones at the configured width; settled rises on the first edge after reset release.
